// File: rtl/hazard_flush_ctrl.sv
// Pipeline hazard/flush sequencer: load-use bubbles, mispredict flushes, dmem waits, HLT drain.
// Optional HAZ_PERF_CNT_EN adds saturating stall/flush/bubble performance counters.
module hazard_flush_ctrl #(
  parameter int REG_ADDR_W   = 4,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ID_EX_MemRead,
  input  logic [REG_ADDR_W-1:0] ID_EX_reg_rd,
  input  logic [REG_ADDR_W-1:0] IF_ID_reg_rs,
  input  logic [REG_ADDR_W-1:0] IF_ID_reg_rt,
  input  logic                  IF_ID_uses_rs,
  input  logic                  IF_ID_uses_rt,
  input  logic                  ID_mispredict,
  input  logic                  IF_ID_is_hlt,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  PC_stall,
  output logic                  IF_ID_stall,
  output logic                  IF_ID_flush,
  output logic                  ID_EX_stall,
  output logic                  ID_EX_flush,
  output logic                  EX_MEM_stall,
  output logic                  MEM_WB_flush,
  output logic                  halted
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count,
  output logic [CNT_W-1:0]      bubble_count
`endif
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] DRAIN    = 2'd2;
  localparam logic [1:0] HALTED   = 2'd3;

  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES);

  logic [1:0]    state, state_d;
  logic [1:0]    ret_state, ret_d;
  logic [DW-1:0] drain_cnt, cnt_d;

  logic mem_wait, load_use;
  logic pc_s, ifid_s, ifid_f, idex_s, idex_f, exmem_s, memwb_f;
  logic stall_all, drain_step, mis_ev, lu_ev;

  assign mem_wait = dmem_req && !dmem_ready;
  assign load_use = ID_EX_MemRead && (ID_EX_reg_rd != '0) &&
                    ((IF_ID_uses_rs && (IF_ID_reg_rs == ID_EX_reg_rd)) ||
                     (IF_ID_uses_rt && (IF_ID_reg_rt == ID_EX_reg_rd)));

  always_comb begin
    state_d    = state;
    ret_d      = ret_state;
    cnt_d      = drain_cnt;
    pc_s       = 1'b0;
    ifid_s     = 1'b0;
    ifid_f     = 1'b0;
    idex_s     = 1'b0;
    idex_f     = 1'b0;
    exmem_s    = 1'b0;
    memwb_f    = 1'b0;
    stall_all  = 1'b0;
    drain_step = 1'b0;
    mis_ev     = 1'b0;
    lu_ev      = 1'b0;

    case (state)
      RUN: begin
        if (mem_wait) begin
          stall_all = 1'b1;
          state_d   = MEM_WAIT;
          ret_d     = RUN;
        end else if (ID_mispredict) begin
          ifid_f = 1'b1;
          mis_ev = 1'b1;
        end else if (load_use) begin
          pc_s   = 1'b1;
          ifid_s = 1'b1;
          idex_f = 1'b1;
          lu_ev  = 1'b1;
        end else if (IF_ID_is_hlt) begin
          pc_s    = 1'b1;
          state_d = DRAIN;
          cnt_d   = DRAIN_INIT;
        end
      end
      MEM_WAIT: begin
        // The release cycle advances the pipeline, so when draining it also counts as a drain cycle.
        if (mem_wait)                stall_all  = 1'b1;
        else if (ret_state == DRAIN) drain_step = 1'b1;
        else                         state_d    = RUN;
      end
      DRAIN: begin
        if (mem_wait) begin
          stall_all = 1'b1;
          state_d   = MEM_WAIT;
          ret_d     = DRAIN;
        end else begin
          drain_step = 1'b1;
        end
      end
      default: begin
        pc_s    = 1'b1;
        ifid_s  = 1'b1;
        idex_s  = 1'b1;
        exmem_s = 1'b1;
      end
    endcase

    if (stall_all) begin
      pc_s    = 1'b1;
      ifid_s  = 1'b1;
      idex_s  = 1'b1;
      exmem_s = 1'b1;
      memwb_f = 1'b1;
    end

    if (drain_step) begin
      pc_s    = 1'b1;
      ifid_f  = 1'b1;
      cnt_d   = drain_cnt - 1'b1;
      state_d = (drain_cnt <= DW'(1)) ? HALTED : DRAIN;
    end
  end

  // Outputs are forced low while reset is held, independent of the Mealy inputs.
  assign PC_stall     = pc_s    && rst_n;
  assign IF_ID_stall  = ifid_s  && rst_n;
  assign IF_ID_flush  = ifid_f  && rst_n;
  assign ID_EX_stall  = idex_s  && rst_n;
  assign ID_EX_flush  = idex_f  && rst_n;
  assign EX_MEM_stall = exmem_s && rst_n;
  assign MEM_WB_flush = memwb_f && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      ret_state <= RUN;
      drain_cnt <= '0;
      halted    <= 1'b0;
    end else begin
      state     <= state_d;
      ret_state <= ret_d;
      drain_cnt <= cnt_d;
      halted    <= (state_d == HALTED);
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (pc_s && (state != HALTED) && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      if (mis_ev && (flush_count != '1))                     flush_count  <= flush_count + 1'b1;
      if (lu_ev && (bubble_count != '1))                     bubble_count <= bubble_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Self-checking bench for hazard_flush_ctrl: directed scenarios plus randomized traffic vs a reference model.
module tb_hazard_flush_ctrl;
  localparam int RW = 4;
  localparam int DC = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ID_EX_MemRead = 1'b0;
  logic [RW-1:0] ID_EX_reg_rd = '0, IF_ID_reg_rs = '0, IF_ID_reg_rt = '0;
  logic IF_ID_uses_rs = 1'b0, IF_ID_uses_rt = 1'b0;
  logic ID_mispredict = 1'b0, IF_ID_is_hlt = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
  logic PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush, EX_MEM_stall, MEM_WB_flush, halted;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cycles, flush_count, bubble_count;
`endif

  hazard_flush_ctrl #(.REG_ADDR_W(RW), .DRAIN_CYCLES(DC), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_reg_rd(ID_EX_reg_rd),
    .IF_ID_reg_rs(IF_ID_reg_rs), .IF_ID_reg_rt(IF_ID_reg_rt),
    .IF_ID_uses_rs(IF_ID_uses_rs), .IF_ID_uses_rt(IF_ID_uses_rt),
    .ID_mispredict(ID_mispredict), .IF_ID_is_hlt(IF_ID_is_hlt),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .PC_stall(PC_stall), .IF_ID_stall(IF_ID_stall), .IF_ID_flush(IF_ID_flush),
    .ID_EX_stall(ID_EX_stall), .ID_EX_flush(ID_EX_flush), .EX_MEM_stall(EX_MEM_stall),
    .MEM_WB_flush(MEM_WB_flush), .halted(halted)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count), .bubble_count(bubble_count)
`endif
  );

  always #5 clk = ~clk;

  // {PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush, EX_MEM_stall, MEM_WB_flush}
  logic [6:0] ctl;
  assign ctl = {PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush, EX_MEM_stall, MEM_WB_flush};

  localparam logic [6:0] P_IDLE  = 7'b0000000;
  localparam logic [6:0] P_LU    = 7'b1100100;
  localparam logic [6:0] P_MIS   = 7'b0010000;
  localparam logic [6:0] P_WAIT  = 7'b1101011;
  localparam logic [6:0] P_HLT   = 7'b1000000;
  localparam logic [6:0] P_DRAIN = 7'b1010000;
  localparam logic [6:0] P_HALT  = 7'b1101010;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: core activity phase, where a memory wait resumes, drain cycles still owed.
  typedef enum int {M_RUN, M_WAIT, M_DRAIN, M_HALT} mode_t;
  mode_t m_mode = M_RUN, m_resume = M_RUN;
  int    m_left = 0;
  int    m_stalls = 0, m_flushes = 0, m_bubbles = 0;

  task automatic model_cycle(output logic [6:0] e);
    bit waiting, hazard;
    mode_t nm;
    nm = m_mode;
    waiting = dmem_req && !dmem_ready;
    hazard  = ID_EX_MemRead && (ID_EX_reg_rd != 0) &&
              ((IF_ID_uses_rs && IF_ID_reg_rs == ID_EX_reg_rd) ||
               (IF_ID_uses_rt && IF_ID_reg_rt == ID_EX_reg_rd));
    e = P_IDLE;
    if (m_mode == M_HALT) begin
      e = P_HALT;
    end else if (waiting && m_mode != M_WAIT) begin
      e = P_WAIT; m_resume = m_mode; nm = M_WAIT;
    end else if (waiting) begin
      e = P_WAIT;
    end else if ((m_mode == M_WAIT && m_resume == M_DRAIN) || m_mode == M_DRAIN) begin
      e = P_DRAIN; m_left = m_left - 1; nm = (m_left == 0) ? M_HALT : M_DRAIN;
    end else if (m_mode == M_WAIT) begin
      nm = M_RUN;
    end else if (ID_mispredict) begin
      e = P_MIS; m_flushes++;
    end else if (hazard) begin
      e = P_LU; m_bubbles++;
    end else if (IF_ID_is_hlt) begin
      e = P_HLT; m_left = DC; nm = M_DRAIN;
    end
    if (e[6] && m_mode != M_HALT) m_stalls++;
    m_mode = nm;
  endtask

  // Called just after a negedge with inputs applied; returns just after the next negedge.
  task automatic step();
    logic [6:0] e;
    #1;
    model_cycle(e);
    check("ctl", {25'd0, ctl}, {25'd0, e});
    @(posedge clk);
    #1;
    check("halted", {31'd0, halted}, {31'd0, (m_mode == M_HALT)});
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ID_EX_MemRead = 0; ID_EX_reg_rd = 0; IF_ID_reg_rs = 0; IF_ID_reg_rt = 0;
    IF_ID_uses_rs = 0; IF_ID_uses_rt = 0; ID_mispredict = 0; IF_ID_is_hlt = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  // Asynchronous reset applied mid-cycle; the mispredict input shows outputs are forced low regardless.
  task automatic do_reset();
    ID_mispredict = 1;
    rst_n = 0;
    #1;
    check("rst_ctl", {25'd0, ctl}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    m_mode = M_RUN; m_resume = M_RUN; m_left = 0;
    m_stalls = 0; m_flushes = 0; m_bubbles = 0;
    @(posedge clk);
    #1;
    check("rst_hold_ctl", {25'd0, ctl}, 32'd0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
  endtask

  task automatic run_to_halt(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while (!halted && n < 20) begin
      step();
      n++;
    end
    check(tag, n, exp_cycles);
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    do_reset();
    #1;
    check("reset_idle", {25'd0, ctl}, {25'd0, P_IDLE});
    step();

    // Load-use on rs, then the same with rd=0
    ID_EX_MemRead = 1; ID_EX_reg_rd = 5; IF_ID_reg_rs = 5; IF_ID_uses_rs = 1;
    #1 check("lu_rd5", {25'd0, ctl}, {25'd0, P_LU});
    step();
    ID_EX_MemRead = 0;
    step();
    ID_EX_MemRead = 1; ID_EX_reg_rd = 0; IF_ID_reg_rs = 0;
    #1 check("lu_rd0", {25'd0, ctl}, {25'd0, P_IDLE});
    step();

    // Mispredict beats load-use on rt
    ID_EX_reg_rd = 7; IF_ID_reg_rt = 7; IF_ID_uses_rt = 1; IF_ID_uses_rs = 0; ID_mispredict = 1;
    #1 check("mis_lu", {25'd0, ctl}, {25'd0, P_MIS});
    step();
    idle_inputs();

    // 4-cycle memory wait with mispredict held throughout
    ID_mispredict = 1; dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1 check("wait_ctl", {25'd0, ctl}, {25'd0, P_WAIT});
      step();
    end
    dmem_ready = 1;
    #1 check("wait_release", {25'd0, ctl}, {25'd0, P_IDLE});
    step();
    dmem_req = 0; dmem_ready = 0;
    #1 check("mis_after_wait", {25'd0, ctl}, {25'd0, P_MIS});
    step();
    idle_inputs();

    // HLT without waits
    IF_ID_is_hlt = 1;
    #1 check("hlt_entry", {25'd0, ctl}, {25'd0, P_HLT});
    step();
    IF_ID_is_hlt = 0;
    #1 check("drain_ctl", {25'd0, ctl}, {25'd0, P_DRAIN});
    run_to_halt("hlt_latency", DC);
    #1 check("halted_ctl", {25'd0, ctl}, {25'd0, P_HALT});
    step();
    do_reset();

    // HLT with a 2-cycle memory wait mid-drain
    IF_ID_is_hlt = 1;
    step();
    IF_ID_is_hlt = 0;
    step();
    dmem_req = 1; dmem_ready = 0;
    step(); step();
    dmem_ready = 1;
    #1 check("drain_release", {25'd0, ctl}, {25'd0, P_DRAIN});
    step();
    idle_inputs();
    run_to_halt("hlt_wait_latency", 1);
    step();
    do_reset();

`ifdef HAZ_PERF_CNT_EN
    for (int i = 0; i < 3; i++) begin
      ID_EX_MemRead = 1; ID_EX_reg_rd = 4'(i + 1); IF_ID_reg_rs = 4'(i + 1); IF_ID_uses_rs = 1;
      step();
      idle_inputs();
      step();
    end
    ID_mispredict = 1; step(); step();
    idle_inputs(); step();
    check("bubble_count", {16'd0, bubble_count}, 32'd3);
    check("flush_count", {16'd0, flush_count}, 32'd2);
    check("stall_cycles", {16'd0, stall_cycles}, 32'd3);
`endif

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      ID_EX_MemRead = ($urandom_range(0, 9) < 4);
      ID_EX_reg_rd  = 4'($urandom_range(0, 3));
      IF_ID_reg_rs  = 4'($urandom_range(0, 3));
      IF_ID_reg_rt  = 4'($urandom_range(0, 3));
      IF_ID_uses_rs = 1'($urandom);
      IF_ID_uses_rt = 1'($urandom);
      ID_mispredict = ($urandom_range(0, 99) < 15);
      IF_ID_is_hlt  = ($urandom_range(0, 99) < 3);
      dmem_req      = ($urandom_range(0, 9) < 3);
      dmem_ready    = 1'($urandom);
      if (m_mode == M_HALT && $urandom_range(0, 3) == 0) do_reset();
      else step();
    end

`ifdef HAZ_PERF_CNT_EN
    idle_inputs();
    #1;
    check("rand_stalls", {16'd0, stall_cycles}, m_stalls);
    check("rand_flushes", {16'd0, flush_count}, m_flushes);
    check("rand_bubbles", {16'd0, bubble_count}, m_bubbles);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_flush_ctrl.md
Name: hazard_flush_ctrl

Overview:
Central pipeline sequencer for the 5-stage CPU. It generates the stall and flush controls for the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Its three sources are load-use hazards, decode-stage branch mispredictions and multi-cycle data-memory waits. It also sequences HLT: it stops fetch, drains the pipeline, then parks the core in a halted state.

Parameters:
REG_ADDR_W, 4, register specifier width
DRAIN_CYCLES, 3, non-stalled cycles for HLT to travel from ID to WB
CNT_W, 16, width of performance counters (used only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ID_EX_MemRead  in  1  instruction in EX is a load
ID_EX_reg_rd  in  REG_ADDR_W  destination register of the instruction in EX
IF_ID_reg_rs  in  REG_ADDR_W  source register rs of the instruction in decode
IF_ID_reg_rt  in  REG_ADDR_W  source register rt of the instruction in decode
IF_ID_uses_rs  in  1  decode instruction reads rs
IF_ID_uses_rt  in  1  decode instruction reads rt
ID_mispredict  in  1  decode-resolved branch disagrees with the pipelined prediction or target
IF_ID_is_hlt  in  1  decode instruction is HLT
dmem_req  in  1  MEM stage issues a data access this cycle
dmem_ready  in  1  data memory completes the access this cycle
PC_stall  out  1  hold PC
IF_ID_stall  out  1  hold IF/ID
IF_ID_flush  out  1  clear IF/ID instruction, prediction and target
ID_EX_stall  out  1  hold ID/EX
ID_EX_flush  out  1  insert bubble into ID/EX
EX_MEM_stall  out  1  hold EX/MEM
MEM_WB_flush  out  1  insert bubble into MEM/WB
halted  out  1  core halted (registered)

Behaviour:
- States: RUN, MEM_WAIT, DRAIN, HALTED. Outputs are Mealy, derived from state plus inputs. `halted` is registered.
- Reset (rst_n=0, async): state=RUN, drain_cnt=0, halted=0.
- In RUN with no event, all control outputs are 0.
- Memory wait has the highest priority.
  - Condition: dmem_req=1 and dmem_ready=0, in RUN or DRAIN.
  - Same cycle: PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall and MEM_WB_flush are all 1.
  - Next state is MEM_WAIT. The return state (RUN or DRAIN) is saved.
- MEM_WAIT:
  - Outputs are held as above.
  - All other events are ignored. drain_cnt is frozen.
  - On dmem_ready=1, stalls drop in that same cycle and the FSM returns to the saved state next cycle.
- Misprediction, evaluated in RUN only:
  - ID_mispredict=1 gives IF_ID_flush=1 for exactly that cycle.
  - The PC is not stalled, so the fetch unit loads the corrected PC.
  - While stalled, decode holds the branch and ID_mispredict stays asserted, so it is acted on the first cycle back in RUN.
- Load-use, RUN only, lower priority than misprediction:
  - Condition: ID_EX_MemRead=1, ID_EX_reg_rd≠0, and (IF_ID_uses_rs and rs==rd) or (IF_ID_uses_rt and rt==rd).
  - Response for one cycle: PC_stall=1, IF_ID_stall=1, ID_EX_flush=1.
  - Register 0 never causes a hazard.
- If misprediction and load-use occur together, the flush takes precedence and no bubble is inserted. The branch resolved in ID has already used forwarded or stalled operands upstream.
- HLT, RUN only, with no memory wait:
  - IF_ID_is_hlt=1 gives PC_stall=1 and IF_ID_flush=0 that cycle.
  - Next state is DRAIN with drain_cnt=DRAIN_CYCLES.
- DRAIN:
  - PC_stall=1 and IF_ID_flush=1 every cycle, so no new instructions are fetched.
  - drain_cnt decrements on each non-memory-wait cycle.
  - When drain_cnt reaches 1 and decrements, the next state is HALTED.
- HALTED:
  - halted=1; PC_stall, IF_ID_stall, ID_EX_stall and EX_MEM_stall are all 1.
  - The only exit is reset.
- Reset asserted mid-MEM_WAIT or mid-DRAIN forces RUN immediately and all outputs to 0.

Optional Feature:
HAZ_PERF_CNT_EN
- Defined: adds outputs `stall_cycles` [CNT_W], `flush_count` [CNT_W] and `bubble_count` [CNT_W].
  - `stall_cycles` increments on each cycle with PC_stall=1 while not HALTED.
  - `flush_count` increments on each IF_ID_flush caused by a misprediction.
  - `bubble_count` increments on each load-use ID_EX_flush.
  - All three saturate at all-ones and reset to 0 on rst_n.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Load-use: EX holds a load with rd=5; decode has rs=5, uses_rs=1 -> one cycle of PC_stall=IF_ID_stall=ID_EX_flush=1, then all 0. Repeat with rd=0 -> no stall.
- Misprediction together with load-use in the same cycle -> IF_ID_flush=1, ID_EX_flush=0, PC_stall=0.
- dmem_req=1 with dmem_ready low for 4 cycles -> stalls and MEM_WB_flush high for exactly 4 cycles, low the cycle dmem_ready=1; an ID_mispredict held throughout -> IF_ID_flush on the following RUN cycle.
- HLT in decode, no memory waits -> halted rises 4 cycles later (1 entry cycle + DRAIN_CYCLES=3); PC_stall is continuous from the HLT cycle onward.
- HLT followed by a 2-cycle memory wait during DRAIN -> halted is delayed by exactly 2 cycles; rst_n pulsed low while HALTED -> halted=0 and all outputs 0 asynchronously.
- With HAZ_PERF_CNT_EN: 3 load-use events and 2 mispredicts -> bubble_count=3, flush_count=2; forced saturation -> counters hold at 0xFFFF.
